// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flop produce one
// difference bit per clock, LSB first. Operation runs through IDLE -> RUN (N cycles) -> DONE.
module serial_subtractor #(
    parameter int unsigned N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_d,
    output logic         o_borrow_out,
    output logic         o_zero
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    a_sr_q, a_sr_d;
    logic [N-1:0]    b_sr_q, b_sr_d;
    logic [N-1:0]    res_q, res_d;
    logic            br_q, br_d;
    logic [N-1:0]    d_q, d_d;
    logic            borrow_q, borrow_d;
    logic            zero_q, zero_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            a_bit;
    logic            b_bit;
    logic            diff_bit;
    logic            br_next;
    logic [N-1:0]    res_next;

    // Full-subtractor cell, next-state and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        br_d     = br_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        a_bit    = a_sr_q[0];
        b_bit    = b_sr_q[0];
        diff_bit = a_bit ^ b_bit ^ br_q;
        br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        res_next = {diff_bit, res_q[N-1:1]};

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    a_sr_d  = i_a;
                    b_sr_d  = i_b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = res_next;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                // Last bit: publish the finished result in the same edge
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = S_DONE;
                    d_d      = res_next;
                    borrow_d = br_next;
                    zero_d   = (res_next == '0);
                    done_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            br_q     <= br_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_d          = d_q;
    assign o_borrow_out = borrow_q;
    assign o_zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at N=8 and N=16: directed vector table,
// start/reset corner sequences, and randomized back-to-back operations against an arithmetic model.
module tb_serial_subtractor;

    logic        i_clk;
    logic        i_reset;

    logic        start8;
    logic [7:0]  a8, b8, d8;
    logic        busy8, done8, br8, zero8;

    logic        start16;
    logic [15:0] a16, b16, d16;
    logic        busy16, done16, br16, zero16;

    int checks;
    int errors;
    logic [7:0] prev_d8;

    serial_subtractor #(.N(8)) u_dut8 (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (start8),
        .i_a          (a8),
        .i_b          (b8),
        .o_busy       (busy8),
        .o_done       (done8),
        .o_d          (d8),
        .o_borrow_out (br8),
        .o_zero       (zero8)
    );

    serial_subtractor #(.N(16)) u_dut16 (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (start16),
        .i_a          (a16),
        .i_b          (b16),
        .o_busy       (busy16),
        .o_done       (done16),
        .o_d          (d16),
        .o_borrow_out (br16),
        .o_zero       (zero16)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_br;
        logic       exp_z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One N=8 operation; inj > 0 pulses a competing start in that RUN cycle
    task automatic run_op8(input string name, input logic [7:0] in_a, input logic [7:0] in_b,
                           input logic [7:0] exp_d, input logic exp_br, input logic exp_z,
                           input int inj);
        int lat;
        @(negedge i_clk);
        a8 = in_a;
        b8 = in_b;
        start8 = 1'b1;
        @(negedge i_clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = 1;
        chk({name, "_busy_run"}, 32'(busy8), 32'(1));
        chk({name, "_hold_run"}, 32'(d8), 32'(prev_d8));
        while (!done8 && lat < 12) begin
            @(negedge i_clk);
            lat++;
            if (lat == inj) begin
                start8 = 1'b1;
                a8 = 8'h10;
                b8 = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            if (inj > 0 && lat == inj + 1)
                chk({name, "_busy_inj"}, 32'(busy8), 32'(1));
        end
        start8 = 1'b0;
        chk({name, "_lat"}, 32'(lat), 32'(9));
        chk({name, "_d"}, 32'(d8), 32'(exp_d));
        chk({name, "_br"}, 32'(br8), 32'(exp_br));
        chk({name, "_z"}, 32'(zero8), 32'(exp_z));
        chk({name, "_busy_done"}, 32'(busy8), 32'(1));
        prev_d8 = exp_d;
        @(negedge i_clk);
        chk({name, "_done_pulse"}, 32'(done8), 32'(0));
        chk({name, "_idle"}, 32'(busy8), 32'(0));
        chk({name, "_hold_idle"}, 32'(d8), 32'(exp_d));
    endtask

    vec_t vecs[8];

    initial begin
        int saw_done;
        checks  = 0;
        errors  = 0;
        prev_d8 = 8'h00;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};

        i_reset = 1'b1;
        start8  = 1'b0; a8  = '0; b8  = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy8", 32'(busy8), 32'(0));
        chk("rst_done8", 32'(done8), 32'(0));
        chk("rst_d8", 32'(d8), 32'(0));
        chk("rst_br8", 32'(br8), 32'(0));
        chk("rst_z8", 32'(zero8), 32'(1));
        chk("rst_busy16", 32'(busy16), 32'(0));
        chk("rst_d16", 32'(d16), 32'(0));
        chk("rst_z16", 32'(zero16), 32'(1));
        i_reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].exp_d, vecs[i].exp_br, vecs[i].exp_z, 0);

        // Start pulsed in RUN cycle 3 must be ignored
        run_op8("ign_start", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 3);
        @(negedge i_clk);
        chk("ign_no_restart", 32'(busy8), 32'(0));

        // Reset in RUN cycle 4 aborts with no done pulse
        @(negedge i_clk);
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        @(negedge i_clk);
        start8 = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("abort_busy", 32'(busy8), 32'(0));
        chk("abort_done", 32'(done8), 32'(0));
        chk("abort_d", 32'(d8), 32'(0));
        chk("abort_br", 32'(br8), 32'(0));
        chk("abort_z", 32'(zero8), 32'(1));
        saw_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            if (done8) saw_done++;
        end
        chk("abort_no_done", 32'(saw_done), 32'(0));
        prev_d8 = 8'h00;
        run_op8("after_abort", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);

        // Randomized back-to-back operations with start held high
        fork
            begin : rand8
                logic [7:0] ra, rb;
                int cnt;
                start8 = 1'b1;
                for (int k = 0; k < 3000; k++) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    a8 = ra;
                    b8 = rb;
                    @(negedge i_clk);
                    @(negedge i_clk);
                    cnt = 2;
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                    while (!done8 && cnt < 16) begin
                        @(negedge i_clk);
                        cnt++;
                    end
                    chk("r8_gap", 32'(cnt), (k == 0) ? 32'(9) : 32'(10));
                    chk("r8_d", 32'(d8), 32'(8'(ra - rb)));
                    chk("r8_br", 32'(br8), 32'(ra < rb));
                    chk("r8_z", 32'(zero8), 32'(ra == rb));
                end
                start8 = 1'b0;
            end
            begin : rand16
                logic [15:0] ra, rb;
                int cnt;
                start16 = 1'b1;
                for (int k = 0; k < 1800; k++) begin
                    ra = 16'($urandom);
                    rb = (k % 50 == 0) ? ra : 16'($urandom);
                    a16 = ra;
                    b16 = rb;
                    @(negedge i_clk);
                    @(negedge i_clk);
                    cnt = 2;
                    a16 = 16'($urandom);
                    b16 = 16'($urandom);
                    while (!done16 && cnt < 24) begin
                        @(negedge i_clk);
                        cnt++;
                    end
                    chk("r16_gap", 32'(cnt), (k == 0) ? 32'(17) : 32'(18));
                    chk("r16_d", 32'(d16), 32'(16'(ra - rb)));
                    chk("r16_br", 32'(br16), 32'(ra < rb));
                    chk("r16_z", 32'(zero16), 32'(ra == rb));
                end
                start16 = 1'b0;
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
